// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled deframer with a one-character valid/ready holding register.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 sampling at ticks 7/8/9; the decision then lands one tick later.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       oversample_rate_edge_i,
  input  logic       rx_i,
  input  logic [1:0] word_len_i,
  input  logic       parity_en_i,
  input  logic       parity_even_i,
  input  logic       parity_stick_i,
  output logic [7:0] rx_data_o,
  output logic       rx_parity_err_o,
  output logic       rx_framing_err_o,
  output logic       rx_break_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_overrun_o,
  output logic       rx_busy_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_sync;
  logic                   tick;
  logic [3:0]             cnt;
  logic [2:0]             idx;
  logic [7:0]             shreg;
  logic                   par_bit_q;
  logic                   par_err_q;
  logic                   decide;
  logic                   sample;
  logic                   last_bit;
  logic                   exp_par;
  logic                   load;
  logic                   brk;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end

  assign rx_sync = sync_q[SYNC_STAGES-1];
  assign tick    = oversample_rate_edge_i;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic s7_q, s8_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s7_q <= 1'b1;
      s8_q <= 1'b1;
    end else if (tick) begin
      if (cnt == 4'd7) s7_q <= rx_sync;
      if (cnt == 4'd8) s8_q <= rx_sync;
    end
  end

  assign decide = tick && (cnt == 4'd9);
  assign sample = (s7_q & s8_q) | (s7_q & rx_sync) | (s8_q & rx_sync);
`else
  assign decide = tick && (cnt == 4'd8);
  assign sample = rx_sync;
`endif

  assign last_bit = (idx == ({1'b0, word_len_i} + 3'd4));
  assign exp_par  = parity_stick_i ? ~parity_even_i : (^shreg ^ ~parity_even_i);
  // A break is an all-zero frame: data, parity (when present) and stop all low.
  assign brk      = (shreg == 8'd0) && (!parity_en_i || !par_bit_q) && !sample;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE:      if (tick && !rx_sync) state_nxt = START;
      START:     if (decide) state_nxt = sample ? IDLE : DATA;
      DATA:      if (decide && last_bit) state_nxt = parity_en_i ? PARITY : STOP;
      PARITY:    if (decide) state_nxt = STOP;
      STOP: begin
        if (decide) begin
          load      = 1'b1;
          state_nxt = sample ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: if (tick && rx_sync) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt       <= 4'd0;
      idx       <= 3'd0;
      shreg     <= 8'd0;
      par_bit_q <= 1'b0;
      par_err_q <= 1'b0;
    end else if (tick) begin
      cnt <= (state == IDLE) ? 4'd0 : cnt + 4'd1;
      if (state == IDLE && !rx_sync) begin
        idx       <= 3'd0;
        shreg     <= 8'd0;
        par_bit_q <= 1'b0;
        par_err_q <= 1'b0;
      end
      if (decide && state == DATA) begin
        shreg[idx] <= sample;
        idx        <= idx + 3'd1;
      end
      if (decide && state == PARITY) begin
        par_bit_q <= sample;
        par_err_q <= (sample != exp_par);
      end
    end
  end

  // A load that coincides with an accept replaces the old character without overrun.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_data_o        <= 8'd0;
      rx_parity_err_o  <= 1'b0;
      rx_framing_err_o <= 1'b0;
      rx_break_o       <= 1'b0;
      rx_valid_o       <= 1'b0;
      rx_overrun_o     <= 1'b0;
    end else begin
      rx_overrun_o <= 1'b0;
      if (load) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_data_o        <= shreg;
          rx_parity_err_o  <= par_err_q;
          rx_framing_err_o <= ~sample;
          rx_break_o       <= brk;
          rx_valid_o       <= 1'b1;
        end else begin
          rx_overrun_o <= 1'b1;
        end
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

  assign rx_busy_o = (state != IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive path, directly downstream of the baud generator.
- Consumes the 16x oversample strobe and samples the asynchronous serial input.
- Deframes start, data, parity and stop bits, and presents each character with its status flags to the RX FIFO/register interface through a valid/ready holding register.
- One character of buffering; overrun is flagged when the consumer stalls.

Parameters:
- SYNC_STAGES, 2, depth of the rx_i synchronizer flops (≥2), reset value 1.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- oversample_rate_edge_i  in  1  one-cycle strobe at 16x baud
- rx_i  in  1  asynchronous serial input, idle high
- word_len_i  in  2  data bits: 0→5, 1→6, 2→7, 3→8
- parity_en_i  in  1  parity bit present
- parity_even_i  in  1  1=even, 0=odd
- parity_stick_i  in  1  stick parity: expected bit = ~parity_even_i
- rx_data_o  out  8  received character, LSB first, unused MSBs zero
- rx_parity_err_o  out  1  parity error, qualified by rx_valid_o
- rx_framing_err_o  out  1  stop bit sampled 0, qualified by rx_valid_o
- rx_break_o  out  1  break detected, qualified by rx_valid_o
- rx_valid_o  out  1  holding register full
- rx_ready_i  in  1  consumer accepts on rx_valid_o & rx_ready_i
- rx_overrun_o  out  1  one-cycle pulse, character lost
- rx_busy_o  out  1  FSM not in IDLE

Behaviour:
Interface:
- Single clock clk_i; reset rst_i asynchronous, active-high.
- All flops clear asynchronously on rst_i, including mid-character; the partial character is discarded.
- Reset values:
  - all outputs 0
  - synchronizer 1
  - FSM IDLE
  - tick counter 0

Timing:
- Timing advances only on cycles where oversample_rate_edge_i=1.
- Bit period = 16 ticks, counted by a 4-bit counter cnt (0..15, wraps).
- Decision point of every bit is the tick where cnt==8.
- Sample value is rx_sync at that tick (see Optional Feature).

FSM states:
- IDLE
  - On a tick with rx_sync==0: cnt←0, go START.
- START
  - At decision: sample 1 → false start, return IDLE, nothing reported.
  - At decision: sample 0 → cnt continues, go DATA, bit index←0.
- DATA
  - Shift each decided sample into bit[idx].
  - After bit word_len+4 (i.e. last data bit): go PARITY if parity_en_i, else STOP.
- PARITY
  - Expected bit:
    - non-stick: XOR(data) ^ ~parity_even_i
    - stick: ~parity_even_i
  - Mismatch sets parity_err.
- STOP
  - At decision, load the holding register (see Holding register) and go to the next state immediately; the remainder of the stop bit is not waited for.
  - Next state:
    - IDLE if stop sample=1
    - WAIT_IDLE if stop sample=0
  - Only the first stop bit is checked.
- WAIT_IDLE
  - Remain until a tick with rx_sync==1, then IDLE.
  - Prevents a break from producing repeated characters.

Holding register:
- Loaded at the STOP decision with data, parity_err, framing_err=~stop, and break.
- break = data==0 & (parity bit==0 or parity disabled) & stop==0.
- Config inputs are sampled live; software changes them only while rx_busy_o=0.
- rx_valid_o: set on load; cleared on rx_valid_o & rx_ready_i.
- Same cycle accept and load: the new character is loaded and rx_valid_o stays 1, with no overrun.
- Load while rx_valid_o=1 and not accepted that cycle:
  - new character dropped
  - old contents kept
  - rx_overrun_o=1 for exactly one cycle
- Data/flags are stable while rx_valid_o=1.

Optional Feature:
- Macro UART_RX_MAJORITY_VOTE_EN.
- Defined: samples captured at ticks cnt==7, 8, 9. The decision at cnt==9 is the 2-of-3 majority. START false-start check and all bit decisions use the majority.
- Undefined: single sample at cnt==8, and the 3-sample flops are not instantiated.
- Decision latency differs by one tick between the two modes; the bench must account for it.

Test Plan:
- Stimulus for all scenarios:
  - oversample strobe every cycle
  - 16 cycles per bit
  - rx_ready_i=1 unless stated
- 8N1 frame with data 0xA5 → one rx_valid_o cycle, rx_data_o=0xA5, all error flags 0, rx_busy_o low after the stop decision.
- 7E1, data 0x41 with parity bit 1 (wrong) → rx_data_o=0x41, rx_parity_err_o=1. Repeat with the correct bit 0 → rx_parity_err_o=0. Also cover stick parity with parity_even_i=1 expecting bit 0.
- rx_i held low for 3 frame times, then high → exactly one character:
  - rx_data_o=0x00, rx_framing_err_o=1, rx_break_o=1
  - no further valid until the line returns high and a new start bit arrives
- Low glitch of 4 cycles on idle line → no rx_valid_o, FSM back to IDLE after the START decision.
- rx_ready_i=0, two back-to-back frames 0x11, 0x22 → rx_data_o stays 0x11, rx_overrun_o pulses once at the second STOP decision. Raising rx_ready_i clears rx_valid_o.
- Assert rst_i during the 4th data bit of 0x5A → outputs 0 immediately. After release, the next clean 0x3C frame is received correctly.
